riscv_fsr_sequencer: RTL
========================

// Module: riscv_fsr_sequencer
// PURPOSE
//  Sequencer for the FP status register (FSR = {rm[2:0], flags[4:0]}).
//  - Merges accrued exception flags from the FMA and misc FP pipes into FSR.
//  - Tracks in-flight FP ops.
//  - Serialises mtfsr/mffsr requests behind an FP-pipe drain, so reads and
//    writes see architecturally ordered state.
//  - Drives the wen/wdata write port of the bypassed FSR register; owns the
//    shadow copy of FSR.
// PARAMETERS
//  FSR_WIDTH     8   FSR width, {rm,flags}
//  NFLAGS        5   exception flag bits, FSR[NFLAGS-1:0]
//  MAX_INFLIGHT  15  max outstanding FP ops; CNT_W = clog2(MAX_INFLIGHT+1)
// PORTS
//  clk             in   1          clock
//  reset           in   1          sync active-high reset
//  fp_issue_val    in   1          FP op issue request
//  fp_issue_rdy    out  1          FP issue allowed
//  fma_wb_val      in   1          FMA pipe retire
//  fma_wb_flags    in   NFLAGS     FMA exception flags
//  misc_wb_val     in   1          misc pipe retire
//  misc_wb_flags   in   NFLAGS     misc exception flags
//  ctrl_req_val    in   1          mtfsr/mffsr request
//  ctrl_req_rdy    out  1          request accepted
//  ctrl_req_wr     in   1          1=mtfsr, 0=mffsr
//  ctrl_req_data   in   FSR_WIDTH  mtfsr write value
//  ctrl_resp_val   out  1          1-cycle response pulse (no backpressure)
//  ctrl_resp_data  out  FSR_WIDTH  FSR value before the op
//  fsr_wen         out  1          FSR register write enable
//  fsr_wdata       out  FSR_WIDTH  FSR register write data
//  rm              out  3          current rounding mode, shadow[7:5]
//  inflight_cnt    out  CNT_W      outstanding FP ops
//  err             out  1          sticky: retire with insufficient count
// BEHAVIOUR
//  Reset: state=IDLE, shadow=0, inflight_cnt=0, fsr_wen=0, fsr_wdata=0,
//   ctrl_resp_val=0, ctrl_resp_data=0, err=0. Reset mid-op drops any
//   accepted request; no response is issued.
//  Shadow: the only FSR state source. fsr_wdata never depends on the FSR
//   register output (its bypass would form a combinational loop).
//  Flag merge: each edge, shadow[NFLAGS-1:0] |= (fma_wb_val ? fma_wb_flags : 0)
//   | (misc_wb_val ? misc_wb_flags : 0). Both pipes may retire in one cycle.
//  Write port: fsr_wen/fsr_wdata are registered. fsr_wen=1 and
//   fsr_wdata = new shadow in the cycle after any shadow change.
//   Flag merge with no new bits set still pulses fsr_wen.
//  Counter: next = cnt + issue_fire - fma_wb_val - misc_wb_val,
//   where issue_fire = fp_issue_val & fp_issue_rdy.
//   Issue plus retire in one cycle leaves cnt unchanged.
//   Retires exceeding cnt+issue_fire: err<=1, cnt clamps to 0.
//  fp_issue_rdy = (state==IDLE) & !ctrl_req_val & (cnt<MAX_INFLIGHT).
//   Control requests take priority over FP issue.
//  ctrl_req_rdy = (state==IDLE). On accept, wr/data are latched.
//  FSM:
//   IDLE : on accept, go to EXEC if cnt==0, else DRAIN.
//   DRAIN: stay until cnt==0, then go to EXEC. Issue is blocked.
//   EXEC : 1 cycle. ctrl_resp_val=1, ctrl_resp_data=shadow (old value).
//          If wr, shadow <= latched data (all FSR_WIDTH bits).
//          A flag merge arriving in EXEC is impossible by construction;
//          if one does, it is ORed into the written value. Then go to IDLE.
//  Latency: accept at T with cnt==0 -> resp at T+1, fsr_wen at T+2.
//   Back-to-back requests: the next accept can happen in the cycle
//   after EXEC.
//  rm and inflight_cnt are driven directly from registers.
// TESTING
//  1 reset, 3x issue, FMA retire flags=5'b00001 then misc 5'b10000
//    -> fsr_wen pulses; fsr_wdata 8'h01 then 8'h11; cnt ends 1; err=0.
//  2 cnt=2, mffsr accepted -> DRAIN; fp_issue_rdy=0 until both retire;
//    resp_data includes both retires' flags; resp arrives 1 cycle after
//    cnt==0.
//  3 shadow=8'h13, mtfsr data=8'h40 with cnt=0 -> resp at T+1 = 8'h13;
//    T+2 fsr_wen=1, fsr_wdata=8'h40; rm=3'b010.
//  4 issue + FMA retire + misc retire same cycle, cnt=1 -> cnt=0;
//    flags ORed; err=0. Then a retire with cnt=0 -> err=1, cnt=0.
//  5 cnt reaches 15 -> fp_issue_rdy=0; one retire -> rdy=1 next cycle.
//  6 reset asserted in DRAIN -> no resp; IDLE, cnt=0, shadow=0,
//    ctrl_req_rdy=1 next cycle.

Source files
------------

// File: rtl/riscv_fsr_sequencer.sv
// rtl/riscv_fsr_sequencer.sv - FP status register sequencer: flag merge, in-flight tracking, mtfsr/mffsr serialisation
module riscv_fsr_sequencer #(
   parameter int FSR_WIDTH    = 8,
   parameter int NFLAGS       = 5,
   parameter int MAX_INFLIGHT = 15,
   localparam int CNT_W       = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 fp_issue_val,
   output logic                 fp_issue_rdy,
   input  logic                 fma_wb_val,
   input  logic [NFLAGS-1:0]    fma_wb_flags,
   input  logic                 misc_wb_val,
   input  logic [NFLAGS-1:0]    misc_wb_flags,
   input  logic                 ctrl_req_val,
   output logic                 ctrl_req_rdy,
   input  logic                 ctrl_req_wr,
   input  logic [FSR_WIDTH-1:0] ctrl_req_data,
   output logic                 ctrl_resp_val,
   output logic [FSR_WIDTH-1:0] ctrl_resp_data,
   output logic                 fsr_wen,
   output logic [FSR_WIDTH-1:0] fsr_wdata,
   output logic [2:0]           rm,
   output logic [CNT_W-1:0]     inflight_cnt,
   output logic                 err
);

   typedef enum logic [1:0] {IDLE, DRAIN, EXEC} state_t;

   state_t               state_q, state_d;
   logic [FSR_WIDTH-1:0] shadow_q, shadow_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 err_q, err_d;
   logic                 wen_q, wen_d;
   logic [FSR_WIDTH-1:0] wdata_q;
   logic                 resp_val_q;
   logic [FSR_WIDTH-1:0] resp_data_q;
   logic                 wr_q;
   logic [FSR_WIDTH-1:0] data_q;

   logic                 issue_fire;
   logic                 accept;
   logic [NFLAGS-1:0]    merge_flags;
   logic                 merge_any;
   logic [CNT_W:0]       cnt_sum, cnt_ret;

   assign ctrl_req_rdy = (state_q == IDLE);
   assign fp_issue_rdy = (state_q == IDLE) & ~ctrl_req_val & (cnt_q < CNT_W'(MAX_INFLIGHT));
   assign issue_fire   = fp_issue_val & fp_issue_rdy;
   assign accept       = ctrl_req_val & ctrl_req_rdy;

   assign merge_flags  = (fma_wb_val  ? fma_wb_flags  : '0) |
                         (misc_wb_val ? misc_wb_flags : '0);
   assign merge_any    = fma_wb_val | misc_wb_val;

   // Retiring more ops than are outstanding is flagged and the count clamps at zero.
   always_comb begin
      cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(issue_fire);
      cnt_ret = (CNT_W+1)'(fma_wb_val) + (CNT_W+1)'(misc_wb_val);
      err_d   = 1'b0;
      cnt_d   = '0;
      if (cnt_ret > cnt_sum) begin
         err_d = 1'b1;
      end else begin
         cnt_d = CNT_W'(cnt_sum - cnt_ret);
      end
   end

   always_comb begin
      state_d                  = state_q;
      shadow_d                 = shadow_q;
      shadow_d[NFLAGS-1:0]     = shadow_q[NFLAGS-1:0] | merge_flags;
      wen_d                    = merge_any;
      case (state_q)
         IDLE: begin
            if (ctrl_req_val) begin
               state_d = (cnt_q == '0) ? EXEC : DRAIN;
            end
         end
         DRAIN: begin
            if (cnt_q == '0) begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            state_d = IDLE;
            if (wr_q) begin
               shadow_d             = data_q;
               shadow_d[NFLAGS-1:0] = data_q[NFLAGS-1:0] | merge_flags;
               wen_d                = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         shadow_q    <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         wen_q       <= 1'b0;
         wdata_q     <= '0;
         resp_val_q  <= 1'b0;
         resp_data_q <= '0;
         wr_q        <= 1'b0;
         data_q      <= '0;
      end else begin
         state_q    <= state_d;
         shadow_q   <= shadow_d;
         cnt_q      <= cnt_d;
         err_q      <= err_q | err_d;
         wen_q      <= wen_d;
         resp_val_q <= (state_d == EXEC);
         if (wen_d) begin
            wdata_q <= shadow_d;
         end
         // The response carries the shadow as seen during the EXEC cycle, before any write.
         if (state_d == EXEC) begin
            resp_data_q <= shadow_d;
         end
         if (accept) begin
            wr_q   <= ctrl_req_wr;
            data_q <= ctrl_req_data;
         end
      end
   end

   assign ctrl_resp_val  = resp_val_q;
   assign ctrl_resp_data = resp_data_q;
   assign fsr_wen        = wen_q;
   assign fsr_wdata      = wdata_q;
   assign rm             = shadow_q[FSR_WIDTH-1 -: 3];
   assign inflight_cnt   = cnt_q;
   assign err            = err_q;

endmodule
